// File: rtl/dii_pkg.sv
// Shared types and constants for the debug-ring (DII) router blocks.
package dii_pkg;

  localparam int DII_DATA_WIDTH = 16;
  localparam int DEST_MSB       = 15;
  localparam int DEST_LSB       = 0;

  typedef struct packed {
    logic [DII_DATA_WIDTH-1:0] data;
    logic                      first;
    logic                      last;
    logic                      valid;
  } dii_flit_t;

  typedef enum logic [1:0] {
    NOWORM     = 2'd0,
    WORM_LOCAL = 2'd1,
    WORM_RING  = 2'd2
  } router_state_e;

endpackage

// File: rtl/dii_out_reg.sv
// One-entry registered output stage; can_load is high when the slot is empty
// or is being drained this cycle, so a ready sink sustains one flit per cycle.
module dii_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  can_load,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  assign can_load = !out_valid || out_ready;

  // Slot register: load wins over drain, drain empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= {DATA_WIDTH{1'b0}};
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_first <= in_first;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ring_router_demux.sv
// Ingress half of a debug-ring router: steers each worm to the local module or
// onward along the ring, based on the destination in its head flit.
module ring_router_demux
  import dii_pkg::*;
#(
  parameter int DATA_WIDTH     = DII_DATA_WIDTH,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               id,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     out_local_data,
  output logic                      out_local_first,
  output logic                      out_local_last,
  output logic                      out_local_valid,
  input  logic                      out_local_ready,
  output logic [DATA_WIDTH-1:0]     out_ring_data,
  output logic                      out_ring_first,
  output logic                      out_ring_last,
  output logic                      out_ring_valid,
  input  logic                      out_ring_ready,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  router_state_e state;
  router_state_e state_next;
  logic          dest_local;
  logic          can_load_local;
  logic          can_load_ring;
  logic          load_local;
  logic          load_ring;
  logic          drop;

  assign dest_local = (in_data[DEST_MSB:DEST_LSB] == id);

  // Next-state, handshake and load steering.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load_local = 1'b0;
    load_ring  = 1'b0;
    drop       = 1'b0;
    case (state)
      NOWORM: begin
        if (in_valid && in_first) begin
          in_ready = dest_local ? can_load_local : can_load_ring;
          if (in_ready) begin
            load_local = dest_local;
            load_ring  = !dest_local;
            if (!in_last) begin
              state_next = dest_local ? WORM_LOCAL : WORM_RING;
            end else begin
              state_next = NOWORM;
            end
          end else begin
            state_next = NOWORM;
          end
        end else if (in_valid) begin
          // Orphan flit outside any worm: swallow it so the ring keeps moving.
          in_ready = 1'b1;
          drop     = 1'b1;
        end else begin
          in_ready = 1'b0;
        end
      end
      WORM_LOCAL: begin
        in_ready   = can_load_local;
        load_local = in_valid && can_load_local;
        if (load_local && in_last) begin
          state_next = NOWORM;
        end else begin
          state_next = WORM_LOCAL;
        end
      end
      WORM_RING: begin
        in_ready  = can_load_ring;
        load_ring = in_valid && can_load_ring;
        if (load_ring && in_last) begin
          state_next = NOWORM;
        end else begin
          state_next = WORM_RING;
        end
      end
      default: begin
        state_next = NOWORM;
      end
    endcase
  end

  // Worm lock state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NOWORM;
    end else begin
      state <= state_next;
    end
  end

  // Saturating orphan-flit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= {DROP_CNT_WIDTH{1'b0}};
    end else if (drop && (drop_count != {DROP_CNT_WIDTH{1'b1}})) begin
      drop_count <= drop_count + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  dii_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_local (
    .clk       (clk),
    .rst       (rst),
    .load      (load_local),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .can_load  (can_load_local),
    .out_data  (out_local_data),
    .out_first (out_local_first),
    .out_last  (out_local_last),
    .out_valid (out_local_valid),
    .out_ready (out_local_ready)
  );

  dii_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .load      (load_ring),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .can_load  (can_load_ring),
    .out_data  (out_ring_data),
    .out_first (out_ring_first),
    .out_last  (out_ring_last),
    .out_valid (out_ring_valid),
    .out_ready (out_ring_ready)
  );

endmodule

// File: tb/tb_ring_router_demux.sv
// Bench for ring_router_demux: directed and random traffic against a queue-based
// model of worm routing, orphan dropping and one-deep output buffering.
module tb_ring_router_demux;
  import dii_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id;
  logic [15:0] in_data;
  logic        in_first, in_last, in_valid, in_ready;
  logic [15:0] out_local_data, out_ring_data;
  logic        out_local_first, out_local_last, out_local_valid, out_local_ready;
  logic        out_ring_first, out_ring_last, out_ring_valid, out_ring_ready;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  // Model: pending flits per output, current worm destination, dropped count.
  dii_flit_t q_loc[$];
  dii_flit_t q_ring[$];
  int        lock  = 0;   // 0 none, 1 local, 2 ring
  int        drops = 0;

  always #5 clk = ~clk;

  ring_router_demux dut (
    .clk(clk), .rst(rst), .id(id),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_local_data(out_local_data), .out_local_first(out_local_first),
    .out_local_last(out_local_last), .out_local_valid(out_local_valid),
    .out_local_ready(out_local_ready),
    .out_ring_data(out_ring_data), .out_ring_first(out_ring_first),
    .out_ring_last(out_ring_last), .out_ring_valid(out_ring_valid),
    .out_ring_ready(out_ring_ready),
    .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check at negedge, advance model, return after posedge.
  task automatic step(input bit v, input bit f, input bit l, input logic [15:0] d,
                      input bit lr, input bit rr, output bit acc);
    bit        exp_rdy;
    bit        can_l, can_r;
    int        dst;
    dii_flit_t fl;
    in_valid = v; in_first = f; in_last = l; in_data = d;
    out_local_ready = lr; out_ring_ready = rr;
    @(negedge clk);
    can_l = (q_loc.size() == 0) || lr;
    can_r = (q_ring.size() == 0) || rr;
    if (lock == 0) begin
      if (!v)      exp_rdy = 1'b0;
      else if (!f) exp_rdy = 1'b1;
      else         exp_rdy = (d == id) ? can_l : can_r;
    end else begin
      exp_rdy = (lock == 1) ? can_l : can_r;
    end
    chk("in_ready", in_ready, exp_rdy);
    chk("local_valid", out_local_valid, q_loc.size() != 0);
    if (q_loc.size() != 0) begin
      chk("local_data", out_local_data, q_loc[0].data);
      chk("local_first", out_local_first, q_loc[0].first);
      chk("local_last", out_local_last, q_loc[0].last);
    end
    chk("ring_valid", out_ring_valid, q_ring.size() != 0);
    if (q_ring.size() != 0) begin
      chk("ring_data", out_ring_data, q_ring[0].data);
      chk("ring_first", out_ring_first, q_ring[0].first);
      chk("ring_last", out_ring_last, q_ring[0].last);
    end
    chk("drop_count", drop_count, drops);
    if (q_loc.size() != 0 && lr) void'(q_loc.pop_front());
    if (q_ring.size() != 0 && rr) void'(q_ring.pop_front());
    acc = v && exp_rdy;
    fl = '{data: d, first: f, last: l, valid: 1'b1};
    if (acc) begin
      if (lock == 0) begin
        if (!f) begin
          if (drops < 255) drops++;
        end else begin
          dst = (d == id) ? 1 : 2;
          if (dst == 1) q_loc.push_back(fl); else q_ring.push_back(fl);
          if (!l) lock = dst;
        end
      end else begin
        if (lock == 1) q_loc.push_back(fl); else q_ring.push_back(fl);
        if (l) lock = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Offer one flit until accepted, bounded.
  task automatic send(input bit f, input bit l, input logic [15:0] d,
                      input bit lr, input bit rr);
    bit acc;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, f, l, d, lr, rr, acc);
      if (acc) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_loc.delete(); q_ring.delete(); lock = 0; drops = 0;
    chk("rst_local_valid", out_local_valid, 1'b0);
    chk("rst_ring_valid", out_ring_valid, 1'b0);
    chk("rst_local_data", {out_local_first, out_local_last, out_local_data}, 18'h0);
    chk("rst_ring_data", {out_ring_first, out_ring_last, out_ring_data}, 18'h0);
    chk("rst_drop", drop_count, 8'd0);
  endtask

  function automatic logic [15:0] rnd_data();
    return 16'($urandom());
  endfunction

  function automatic logic [15:0] not_id();
    logic [15:0] r;
    r = 16'($urandom());
    if (r == id) r = r ^ 16'h8000;
    return r;
  endfunction

  initial begin
    bit acc;
    id = 16'h0005; rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = 16'h0000; out_local_ready = 1'b1; out_ring_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    do_reset();

    // 3-flit local worm.
    send(1'b1, 1'b0, 16'h0005, 1'b1, 1'b1);
    send(1'b0, 1'b0, rnd_data(), 1'b1, 1'b1);
    send(1'b0, 1'b1, rnd_data(), 1'b1, 1'b1);
    idle(2);

    // 4-flit ring worm.
    send(1'b1, 1'b0, 16'h0009, 1'b1, 1'b1);
    send(1'b0, 1'b0, 16'h0005, 1'b1, 1'b1);
    send(1'b0, 1'b0, rnd_data(), 1'b1, 1'b1);
    send(1'b0, 1'b1, rnd_data(), 1'b1, 1'b1);
    idle(2);
    chk("lock_after_ring", lock, 0);

    // Single-flit packets alternating destinations.
    for (int i = 0; i < 10; i++)
      send(1'b1, 1'b1, (i % 2 == 0) ? 16'h0005 : not_id(), 1'b1, 1'b1);
    idle(2);

    // Ring worm stalled by downstream, local packet queued behind it.
    send(1'b1, 1'b0, 16'h0100, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, acc);
    send(1'b0, 1'b0, 16'h1234, 1'b1, 1'b1);
    send(1'b0, 1'b1, 16'h4321, 1'b1, 1'b1);
    send(1'b1, 1'b1, 16'h0005, 1'b1, 1'b1);
    idle(2);

    // Orphan flits saturate the drop counter.
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'b0, 1'($urandom()), rnd_data(), 1'b1, 1'b1, acc);
    idle(1);
    chk("drop_saturated", drop_count, 8'd255);

    // Reset in the middle of a local worm.
    do_reset();
    send(1'b1, 1'b0, 16'h0005, 1'b1, 1'b1);
    send(1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1);
    do_reset();
    send(1'b0, 1'b0, 16'hBBBB, 1'b1, 1'b1);
    send(1'b0, 1'b1, 16'hCCCC, 1'b1, 1'b1);
    idle(1);
    chk("drop_after_reset", drop_count, 8'd2);
    send(1'b1, 1'b1, 16'h0777, 1'b1, 1'b1);
    idle(2);

    // Random traffic with random backpressure, including mid-worm first flags.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1) ? id : not_id(),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), acc);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_router_demux.md
Name: ring_router_demux

Overview:
- Ingress half of a debug-ring router. Takes the incoming ring DII stream and steers each packet (worm) either to the local module or onward along the ring.
- The destination is decoded from the first flit of each packet.
- Each output has a one-entry registered stage, which breaks the timing path between ring hops.
- Pairs with the egress mux that merges ring and local traffic back onto the ring.

Parameters:
- DATA_WIDTH, 16, flit payload width; the destination field is data[15:0] of the first flit.
- DROP_CNT_WIDTH, 8, width of the saturating orphan-flit drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id  in  16  this router's module address; static after reset
- in_data  in  DATA_WIDTH  incoming ring flit payload
- in_first  in  1  flit is head of packet
- in_last  in  1  flit is tail of packet
- in_valid  in  1  flit present
- in_ready  out  1  flit accepted when in_valid && in_ready
- out_local_data  out  DATA_WIDTH  flit to local module
- out_local_first  out  1  head marker
- out_local_last  out  1  tail marker
- out_local_valid  out  1  local flit present
- out_local_ready  in  1  local sink accepts
- out_ring_data  out  DATA_WIDTH  flit forwarded on ring
- out_ring_first  out  1  head marker
- out_ring_last  out  1  tail marker
- out_ring_valid  out  1  ring flit present
- out_ring_ready  in  1  downstream ring accepts
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped orphan flits

Behaviour:
- Reset:
  - state=NOWORM.
  - Both output registers empty: out_*_valid=0; out_*_data/first/last=0.
  - drop_count=0.
- Output stage, per output:
  - One register {data, first, last, valid}.
  - can_load_X = !out_X_valid || out_X_ready.
  - On load, the register takes the input flit and sets valid=1.
  - Else, when out_X_valid && out_X_ready, valid clears to 0.
  - Latency from accepted input to output valid: 1 cycle.
  - Full throughput of 1 flit/cycle while the sink is ready.
- Destination decode, first flit only: dest_local = (in_data[15:0] == id). All other values route to ring.
- State machine {NOWORM, WORM_LOCAL, WORM_RING}:
  - NOWORM, in_valid && in_first:
    - target = local if dest_local, else ring.
    - in_ready = can_load_target; on accept, load the target register.
    - If !in_last, next state is WORM_<target>.
    - Single-flit packets (first && last) stay in NOWORM.
  - NOWORM, in_valid && !in_first (orphan flit):
    - in_ready=1 and the flit is discarded; neither output is loaded.
    - drop_count increments, saturating at all-ones.
  - NOWORM, !in_valid: in_ready=0.
  - WORM_LOCAL / WORM_RING:
    - in_ready = can_load of the locked output.
    - Accepted flits load the locked output unconditionally, with no decode and no first check.
    - A flit with first=1 mid-worm is forwarded as-is.
    - On accept of a flit with last=1, next state is NOWORM.
- The non-target output is never loaded while a worm is locked. It may still drain its residual flit independently.
- Back-to-back packets to different outputs are legal on consecutive cycles. A packet to a stalled output blocks the input (head-of-line blocking); this is intended.
- in_ready depends combinationally on out_X_ready and on the in_first/in_data decode. There is no combinational path from in_valid to out_*_valid.
- Reset mid-worm:
  - Returns to NOWORM and empties both registers.
  - Remaining flits of the interrupted packet arrive with first=0 and are dropped as orphans, counted.
- id changes are only honoured at packet heads. The spec requires id static; behaviour mid-worm is not defined.

Decomposition:
- Shared package (dii_pkg): DATA_WIDTH default, the flit struct typedef {data, first, last, valid}, the destination field range constant, and the router state enum.
- One natural sub-module: dii_out_reg, the one-entry registered output stage with load/drain handshake. It is instantiated twice (local, ring).

Test Plan:
- id=0x0005; 3-flit packet, head data=0x0005, sinks always ready -> 3 flits on local on consecutive cycles, 1-cycle latency, first/last preserved; ring idle.
- Head data=0x0009, 4 flits -> all 4 on ring, identical payload; local_valid never asserts; state returns to NOWORM after the tail.
- Single-flit packets alternating local/ring destinations, every cycle -> each appears on the correct output one cycle later; in_ready stays 1 throughout.
- Ring worm of 3 flits with out_ring_ready=0 for 5 cycles after the first flit -> in_ready=0 during the stall; no flit lost or duplicated; a local packet queued behind it waits until the ring tail is accepted.
- Orphan flits: 300 flits with first=0 in NOWORM -> in_ready=1, no output activity, drop_count saturates at 255.
- Assert rst after the 2nd flit of a 4-flit local worm -> outputs clear next cycle; flits 3–4 are dropped; drop_count=2; the next head routes correctly.
